// File: rtl/tspi_pkg.sv
// Shared TSPI master types: engine FSM states and the command word latched at accept.
package tspi_pkg;

    localparam int TspiDataWidth = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        SELECTED,
        HOLD,
        GUARD
    } tspi_state_e;

    typedef struct packed {
        logic [TspiDataWidth-1:0] data;
        logic                     last;
    } tspi_cmd_t;

endpackage

// File: rtl/tspi_clk_gen.sv
// SCK phase timer: a D-cycle down-counter whose expiry (tick) paces every phase, plus the SCK flop.
// Latency: rise/fall strobes are combinational; SCK changes on the edge that ends the strobe cycle.
module tspi_clk_gen #(
    parameter int ClkDivWidth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   load_i,
    input  logic                   toggle_en_i,
    input  logic                   force_rise_i,
    input  logic [ClkDivWidth-1:0] div_i,
    output logic                   tick_o,
    output logic                   rise_o,
    output logic                   fall_o,
    output logic                   sck_o
);

    logic [ClkDivWidth-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == '0);
    assign rise_o = force_rise_i | (tick_o & toggle_en_i & ~sck_o);
    assign fall_o = tick_o & sck_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_o <= 1'b0;
        end else begin
            // Parked at the reload value while disabled so the first enabled phase lasts exactly D.
            if (load_i || tick_o || !en_i) begin
                cnt_q <= div_i;
            end else begin
                cnt_q <= cnt_q - ClkDivWidth'(1);
            end
            if (rise_o) begin
                sck_o <= 1'b1;
            end else if (fall_o) begin
                sck_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tspi_master.sv
// Byte-wide mode-0 SPI master; accept-to-response 17*D+1 cycles from IDLE, 16*D+1 while CS is held.
// Single-entry response register: no command is accepted while a response is still pending.
module tspi_master
    import tspi_pkg::*;
#(
    parameter int ClkDivWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ClkDivWidth-1:0]   clk_div_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [TspiDataWidth-1:0] cmd_data_i,
    input  logic                     cmd_last_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [TspiDataWidth-1:0] rsp_data_o,
    output logic                     busy_o,
    output logic                     tspi_clk_o,
    output logic                     tspi_mosi_o,
    input  logic                     tspi_miso_i,
    output logic                     tspi_cs_no
);

    localparam logic [3:0] LastBit = 4'(TspiDataWidth);

    tspi_state_e              state_q, state_d;
    tspi_cmd_t                cmd_q;
    logic [ClkDivWidth-1:0]   div_q, div_sel;
    logic [TspiDataWidth-1:0] rx_q;
    logic [3:0]               bit_cnt_q;
    logic                     cs_n_d, rsp_valid_d, ready_d;
    logic                     accept, done, gen_en, toggle_en, force_rise;
    logic                     tick, rise, fall;

    assign accept      = cmd_valid_i & cmd_ready_o;
    assign div_sel     = accept ? clk_div_i : div_q;
    assign gen_en      = state_q inside {SETUP, SHIFT, HOLD, GUARD};
    assign busy_o      = (state_q != IDLE);
    assign tspi_mosi_o = cmd_q.data[TspiDataWidth-1];

    tspi_clk_gen #(
        .ClkDivWidth(ClkDivWidth)
    ) u_clk_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (gen_en),
        .load_i      (accept),
        .toggle_en_i (toggle_en),
        .force_rise_i(force_rise),
        .div_i       (div_sel),
        .tick_o      (tick),
        .rise_o      (rise),
        .fall_o      (fall),
        .sck_o       (tspi_clk_o)
    );

    always_comb begin
        state_d    = state_q;
        cs_n_d     = tspi_cs_no;
        done       = 1'b0;
        toggle_en  = 1'b0;
        force_rise = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                if (accept) begin
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                toggle_en = 1'b1;
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                toggle_en = (bit_cnt_q != LastBit);
                if (tick && !tspi_clk_o && bit_cnt_q == LastBit) begin
                    done    = 1'b1;
                    state_d = cmd_q.last ? HOLD : SELECTED;
                end
            end
            SELECTED: begin
                // CS is already settled, so the first rising edge coincides with accept.
                if (accept) begin
                    force_rise = 1'b1;
                    state_d    = SHIFT;
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = 1'b1;
                    state_d = GUARD;
                end
            end
            GUARD: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = done | (rsp_valid_o & ~rsp_ready_i);
        ready_d     = (state_d == IDLE || state_d == SELECTED) && !rsp_valid_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tspi_cs_no  <= 1'b1;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            cmd_q       <= '0;
            div_q       <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tspi_cs_no  <= cs_n_d;
            cmd_ready_o <= ready_d;
            rsp_valid_o <= rsp_valid_d;
            if (done) rsp_data_o <= rx_q;
            if (rise) rx_q <= {rx_q[TspiDataWidth-2:0], tspi_miso_i};
            if (accept) begin
                cmd_q     <= '{data: cmd_data_i, last: cmd_last_i};
                div_q     <= clk_div_i;
                bit_cnt_q <= rise ? 4'd1 : 4'd0;
            end else begin
                // The final falling edge leaves MOSI on bit 0 rather than shifting in filler.
                if (fall && bit_cnt_q != LastBit) begin
                    cmd_q.data <= {cmd_q.data[TspiDataWidth-2:0], 1'b0};
                end
                if (rise) bit_cnt_q <= bit_cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tspi_master.sv
// Scoreboarded bench for tspi_master: directed bytes, a bit-stream MISO slave and pad-line monitors.
module tb_tspi_master;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] clk_div_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_data_i;
    logic       cmd_last_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_data_o;
    logic       busy_o;
    logic       tspi_clk_o;
    logic       tspi_mosi_o;
    logic       tspi_miso_i;
    logic       tspi_cs_no;

    tspi_master #(.ClkDivWidth(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clk_div_i  (clk_div_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_data_i (cmd_data_i),
        .cmd_last_i (cmd_last_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_data_o (rsp_data_o),
        .busy_o     (busy_o),
        .tspi_clk_o (tspi_clk_o),
        .tspi_mosi_o(tspi_mosi_o),
        .tspi_miso_i(tspi_miso_i),
        .tspi_cs_no (tspi_cs_no)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_dat[$];
    int         sb_cyc[$];

    int          rise_cnt = 0, cs_fall_cnt = 0, cs_low_last = 0, cs_run = 0;
    int          hi_run = 0, lo_run = 0, last_hi = 0, hi_bad = 0, lo_bad = 0, mosi0 = 0;
    int          exp_d = 1;
    logic [31:0] mosi_cap = '0;
    bit          sck_prev = 1'b0, cs_prev = 1'b1, rv_prev = 1'b0;

    // MISO slave: presents stream bit k before the k-th rising SCK edge of the test.
    logic [63:0] miso_stream;
    int          miso_base;
    int          miso_idx;
    bit          loopback;
    always_comb begin
        miso_idx    = rise_cnt - miso_base;
        tspi_miso_i = 1'b0;
        if (loopback) tspi_miso_i = tspi_mosi_o;
        else if (miso_idx >= 0 && miso_idx < 64) tspi_miso_i = miso_stream[63-miso_idx];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic mon_loop();
        logic [7:0] e;
        int         c;
        forever begin
            @(negedge clk_i);
            if (rsp_valid_o && !rv_prev) begin
                if (sb_dat.size() == 0) begin
                    chk("rsp_unexpected", rsp_data_o, 'hFFFF);
                end else begin
                    e = sb_dat.pop_front();
                    c = sb_cyc.pop_front();
                    chk("rsp_data", rsp_data_o, e);
                    chk("rsp_latency_cycle", cyc, c);
                end
            end
            rv_prev = rsp_valid_o;
            if (tspi_clk_o && !sck_prev) begin
                rise_cnt++;
                mosi_cap = {mosi_cap[30:0], tspi_mosi_o};
                if (lo_run != exp_d) lo_bad++;
            end
            if (!tspi_clk_o && sck_prev) begin
                last_hi = hi_run;
                if (hi_run != exp_d) hi_bad++;
            end
            if (!tspi_cs_no && cs_prev) cs_fall_cnt++;
            if (tspi_cs_no && !cs_prev) cs_low_last = cs_run;
            if (tspi_cs_no) cs_run = 0;
            else cs_run++;
            if (tspi_clk_o) begin
                hi_run++;
                lo_run = 0;
            end else begin
                hi_run = 0;
                if (!tspi_cs_no) lo_run++;
                else lo_run = 0;
            end
            if (!tspi_cs_no && !tspi_mosi_o) mosi0++;
            sck_prev = tspi_clk_o;
            cs_prev  = tspi_cs_no;
        end
    endtask

    // Offers one command, waits for acceptance and books the expected response.
    task automatic send(input logic [7:0] d, input logic last, input logic [7:0] div,
                        input logic [7:0] exp_rsp, input int lat_mult);
        int n = 0;
        cmd_data_i  = d;
        cmd_last_i  = last;
        clk_div_i   = div;
        cmd_valid_i = 1'b1;
        while (!cmd_ready_o && n < 3000) begin
            step();
            n++;
        end
        if (!cmd_ready_o) begin
            chk("cmd_accept_timeout", 0, 1);
        end else begin
            sb_dat.push_back(exp_rsp);
            sb_cyc.push_back(cyc + lat_mult * (int'(div) + 1) + 1);
        end
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while ((busy_o || sb_dat.size() != 0) && n < max) begin
            step();
            n++;
        end
        if (busy_o || sb_dat.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_sb(input int max);
        int n = 0;
        while (sb_dat.size() != 0 && n < max) begin
            step();
            n++;
        end
        if (sb_dat.size() != 0) chk("response_timeout", 0, 1);
    endtask

    task automatic start_stream(input logic [63:0] s);
        miso_stream = s;
        miso_base   = rise_cnt;
    endtask

    initial begin
        int r0, f0, hb0, lb0, m0, n, viol;
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_data_i = '0; cmd_last_i = 1'b0;
        clk_div_i = '0; rsp_ready_i = 1'b1; loopback = 1'b0;
        miso_stream = '0; miso_base = 0;
        fork
            mon_loop();
        join_none
        step(); step();
        chk("reset_cs_n", tspi_cs_no, 1);
        chk("reset_sck", tspi_clk_o, 0);
        chk("reset_mosi", tspi_mosi_o, 0);
        chk("reset_cmd_ready", cmd_ready_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_data", rsp_data_o, 0);
        chk("reset_busy", busy_o, 0);
        rst_i = 1'b0;
        step(); step();

        // Loopback single byte, D=1
        loopback = 1'b1; exp_d = 1;
        r0 = rise_cnt; f0 = cs_fall_cnt;
        send(8'hA5, 1'b1, 8'd0, 8'hA5, 17);
        wait_idle(200);
        chk("t1_sck_pulses", rise_cnt - r0, 8);
        chk("t1_cs_low_cycles", cs_low_last, 18);
        chk("t1_cs_assertions", cs_fall_cnt - f0, 1);
        chk("t1_cs_high_after", tspi_cs_no, 1);
        loopback = 1'b0;

        // Fixed MISO pattern, D=4
        exp_d = 4;
        start_stream({8'h3C, 56'h0});
        r0 = rise_cnt; hb0 = hi_bad; lb0 = lo_bad; m0 = mosi0;
        send(8'hFF, 1'b1, 8'd3, 8'h3C, 17);
        wait_idle(300);
        chk("t2_sck_pulses", rise_cnt - r0, 8);
        chk("t2_bad_high_widths", hi_bad - hb0, 0);
        chk("t2_bad_low_widths", lo_bad - lb0, 0);
        chk("t2_mosi_low_cycles", mosi0 - m0, 0);

        // Burst of three bytes, D=2, CS held
        exp_d = 2;
        start_stream({8'h81, 8'h42, 8'h24, 40'h0});
        f0 = cs_fall_cnt;
        send(8'h01, 1'b0, 8'd1, 8'h81, 17);
        send(8'h02, 1'b0, 8'd1, 8'h42, 16);
        send(8'h03, 1'b1, 8'd1, 8'h24, 16);
        wait_idle(500);
        chk("t3_cs_assertions", cs_fall_cnt - f0, 1);
        chk("t3_mosi_bytes", mosi_cap[23:0], 24'h010203);

        // Response backpressure stalls the burst
        exp_d = 1;
        start_stream({8'h96, 8'h69, 48'h0});
        rsp_ready_i = 1'b0;
        send(8'hE7, 1'b0, 8'd0, 8'h96, 17);
        cmd_data_i = 8'h18; cmd_last_i = 1'b1; cmd_valid_i = 1'b1;
        n = 0;
        while (!rsp_valid_o && n < 100) begin
            step();
            n++;
        end
        chk("t4_rsp_pending", rsp_valid_o, 1);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cmd_ready_o || tspi_cs_no || tspi_clk_o) viol++;
        end
        chk("t4_stall_violations", viol, 0);
        rsp_ready_i = 1'b1;
        send(8'h18, 1'b1, 8'd0, 8'h69, 16);
        wait_idle(200);
        chk("t4_mosi_bytes", mosi_cap[15:0], 16'hE718);

        // Reset in the middle of a byte
        exp_d = 3;
        start_stream({8'hFF, 8'h5A, 48'h0});
        r0 = rise_cnt;
        send(8'hC3, 1'b1, 8'd2, 8'hFF, 17);
        n = 0;
        while (rise_cnt - r0 < 4 && n < 200) begin
            step();
            n++;
        end
        chk("t5_reached_bit4", rise_cnt - r0, 4);
        #1 rst_i = 1'b1;
        #1;
        chk("t5_rst_cs_n", tspi_cs_no, 1);
        chk("t5_rst_sck", tspi_clk_o, 0);
        chk("t5_rst_rsp_valid", rsp_valid_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        sb_dat.delete();
        sb_cyc.delete();
        step(); step();
        rst_i = 1'b0;
        step(); step();
        start_stream({8'h5A, 56'h0});
        send(8'h3C, 1'b1, 8'd2, 8'h5A, 17);
        wait_idle(300);
        chk("t5_fresh_mosi", mosi_cap[7:0], 8'h3C);

        // Divider change mid-byte only affects the next byte
        exp_d = 2;
        start_stream({8'hA0, 8'h0B, 48'h0});
        send(8'h11, 1'b0, 8'd1, 8'hA0, 17);
        step(); step(); step();
        clk_div_i = 8'd7;
        wait_sb(200);
        chk("t6_first_high_width", last_hi, 2);
        send(8'h22, 1'b1, 8'd7, 8'h0B, 16);
        wait_idle(600);
        chk("t6_second_high_width", last_hi, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
